// File: rtl/fcl_multi_controller_pkg.sv
// Shared definitions for the field_cfg_loader multi-configuration controller.
//   fcl_state_t    : controller FSM states (also exported on the debug port)
//   FCL_NO_REQ     : request code meaning "no request / idle"
//   fcl_req_width  : helper that sizes a request code for a given N_CFG
//                    (codes 1..N_CFG plus the 0 "none" code)
package fcl_multi_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARMED    = 3'd1,
    ST_START    = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_WAIT_END = 3'd4
  } fcl_state_t;

  localparam int FCL_N_CFG_DEFAULT       = 4;
  localparam int FCL_ACK_TIMEOUT_DEFAULT = 16;
  localparam int FCL_NO_REQ              = 0;

  function automatic int fcl_req_width(input int n_cfg);
    return $clog2(n_cfg + 1);
  endfunction

endpackage

// File: rtl/fcl_multi_controller_prio_enc.sv
// fcl_req_prio_enc: combinational priority encoder for load commands.
// Converts an N_CFG-bit command vector into a request code; the lowest
// set bit wins and bit k maps to code k+1. Other set bits are dropped.
// Ports:
//   cmd   in  N_CFG  command bits (bit k = configuration k+1)
//   valid out 1      at least one command bit set
//   code  out REQ_W  winning request code, 0 when no bit is set
module fcl_req_prio_enc #(
  parameter int N_CFG = 4,
  parameter int REQ_W = $clog2(N_CFG + 1)
) (
  input  logic [N_CFG-1:0] cmd,
  output logic             valid,
  output logic [REQ_W-1:0] code
);

  // Scan from the top down so the lowest set bit is written last and wins.
  always_comb begin
    valid = 1'b0;
    code  = '0;
    for (int k = N_CFG - 1; k >= 0; k--) begin
      if (cmd[k]) begin
        valid = 1'b1;
        code  = REQ_W'(k + 1);
      end
    end
  end

endmodule

// File: rtl/fcl_multi_controller.sv
// fcl_multi_controller: arbitrates configuration load commands, waits for
// the field to be paused, strobes the loader and tracks its busy flag.
// A one-deep pending slot holds a command that arrives while a load is in
// flight; an ack watchdog aborts a load the loader never acknowledges.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_cmd_load_cfg    bit k pulse requests configuration k+1
//   i_fcl_allowed     field paused, loading permitted
//   i_is_loading      loader busy flag
//   o_go              1-cycle start strobe to the loader
//   o_cur_req         request code being served (0 when idle)
//   o_busy            controller not idle
//   o_pending_valid   pending slot occupied
//   o_done            1-cycle pulse, load finished
//   o_timeout         1-cycle pulse, loader never acknowledged o_go
//   dbg_state         current FSM state
//
// Loader handshake: o_go is a single-cycle request; the loader acknowledges
// by raising i_is_loading within ACK_TIMEOUT cycles and signals completion
// by dropping it. After o_go, i_fcl_allowed is no longer consulted.
module fcl_multi_controller
  import fcl_multi_controller_pkg::*;
#(
  parameter  int N_CFG       = FCL_N_CFG_DEFAULT,
  parameter  int ACK_TIMEOUT = FCL_ACK_TIMEOUT_DEFAULT,
  localparam int REQ_W       = fcl_req_width(N_CFG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CFG-1:0] i_cmd_load_cfg,
  input  logic             i_fcl_allowed,
  input  logic             i_is_loading,
  output logic             o_go,
  output logic [REQ_W-1:0] o_cur_req,
  output logic             o_busy,
  output logic             o_pending_valid,
  output logic             o_done,
  output logic             o_timeout,
  output fcl_state_t       dbg_state
);

  typedef logic [REQ_W-1:0] fcl_req_t;

  localparam int       WD_W    = $clog2(ACK_TIMEOUT);
  localparam fcl_req_t NO_REQ  = fcl_req_t'(FCL_NO_REQ);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(ACK_TIMEOUT - 1);

  fcl_state_t      state, state_n;
  fcl_req_t        cur, cur_n;
  fcl_req_t        pend, pend_n;
  logic            pend_v, pend_v_n;
  logic [WD_W-1:0] wd, wd_n;
  logic            go, done, tmo;

  logic     enc_valid;
  fcl_req_t enc_code;

  fcl_req_prio_enc #(
    .N_CFG (N_CFG),
    .REQ_W (REQ_W)
  ) u_prio_enc (
    .cmd   (i_cmd_load_cfg),
    .valid (enc_valid),
    .code  (enc_code)
  );

  always_comb begin
    state_n  = state;
    cur_n    = cur;
    pend_n   = pend;
    pend_v_n = pend_v;
    wd_n     = wd;
    go       = 1'b0;
    done     = 1'b0;
    tmo      = 1'b0;

    case (state)
      ST_IDLE: begin
        // A queued request is older than anything arriving now, so it is
        // served first and the new command takes its place in the slot.
        if (pend_v) begin
          cur_n    = pend;
          pend_n   = enc_code;
          pend_v_n = enc_valid;
          state_n  = ST_ARMED;
        end else if (enc_valid) begin
          cur_n   = enc_code;
          state_n = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (enc_valid) cur_n = enc_code;
        if (i_fcl_allowed) state_n = ST_START;
      end
      ST_START: begin
        go      = 1'b1;
        wd_n    = '0;
        state_n = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        // An ack arriving on the expiry cycle takes priority over the abort.
        if (i_is_loading) begin
          state_n = ST_WAIT_END;
        end else if (wd == WD_LAST) begin
          tmo     = 1'b1;
          cur_n   = NO_REQ;
          state_n = ST_IDLE;
        end else begin
          wd_n = wd + WD_W'(1);
        end
      end
      ST_WAIT_END: begin
        if (!i_is_loading) begin
          done    = 1'b1;
          cur_n   = NO_REQ;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Once the loader has been strobed, new commands queue; last one wins.
    if (enc_valid && (state inside {ST_START, ST_WAIT_ACK, ST_WAIT_END})) begin
      pend_n   = enc_code;
      pend_v_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cur    <= NO_REQ;
      pend   <= NO_REQ;
      pend_v <= 1'b0;
      wd     <= '0;
    end else begin
      state  <= state_n;
      cur    <= cur_n;
      pend   <= pend_n;
      pend_v <= pend_v_n;
      wd     <= wd_n;
    end
  end

  // Strobes are masked by reset so a reset cycle never emits a pulse.
  assign o_go            = go & ~rst;
  assign o_done          = done & ~rst;
  assign o_timeout       = tmo & ~rst;
  assign o_cur_req       = cur;
  assign o_busy          = (state != ST_IDLE);
  assign o_pending_valid = pend_v;
  assign dbg_state       = state;

endmodule

// File: tb/tb_fcl_multi_controller.sv
// Testbench for fcl_multi_controller: directed table, hand-written corner
// sequences, then randomized stimulus against a transaction-level model.
module tb_fcl_multi_controller;
  import fcl_multi_controller_pkg::*;

  localparam int N     = 4;
  localparam int ACK_T = 16;
  localparam int RW    = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst     = 1'b1;
  logic [N-1:0]  cmd     = '0;
  logic          allowed = 1'b0;
  logic          loading = 1'b0;

  logic          o_go, o_busy, o_pending_valid, o_done, o_timeout;
  logic [RW-1:0] o_cur_req;
  fcl_state_t    dbg_state;

  fcl_multi_controller #(
    .N_CFG       (N),
    .ACK_TIMEOUT (ACK_T)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_cmd_load_cfg  (cmd),
    .i_fcl_allowed   (allowed),
    .i_is_loading    (loading),
    .o_go            (o_go),
    .o_cur_req       (o_cur_req),
    .o_busy          (o_busy),
    .o_pending_valid (o_pending_valid),
    .o_done          (o_done),
    .o_timeout       (o_timeout),
    .dbg_state       (dbg_state)
  );

  // Observed outputs packed as {go, cur_req, busy, pending, done, timeout}.
  logic [7:0] act;
  assign act = {o_go, o_cur_req, o_busy, o_pending_valid, o_done, o_timeout};

  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] ov(input bit go, input int cur, input bit busy,
                                    input bit pv, input bit done, input bit to);
    return {go, 3'(cur), busy, pv, done, to};
  endfunction

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];

  task automatic check(input string name);
    logic [7:0] e;
    e = exp_q.pop_front();
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got %b expected %b (go,cur[3],busy,pend,done,tmo)", name, act, e);
    end
  endtask

  // ---------------- driver ----------------
  // Inputs change 1 time unit after the rising edge; outputs are sampled on
  // the falling edge of the same cycle.
  task automatic cyc(input string name, input bit r, input logic [N-1:0] c,
                     input bit a, input bit l, input logic [7:0] e);
    rst = r; cmd = c; allowed = a; loading = l;
    exp_q.push_back(e);
    @(negedge clk);
    check(name);
    @(posedge clk); #1;
  endtask

  // ---------------- reference model ----------------
  // m_cur: request being served (0 = idle); m_age: cycles since the go
  // strobe (-1 = not launched yet); m_acked: loader has shown busy.
  int m_cur = 0, m_pend = 0, m_age = -1;
  bit m_acked = 1'b0;

  task automatic rcyc(input bit r, input logic [N-1:0] c, input bit a, input bit l);
    logic [N-1:0] iso;
    int low;
    logic [7:0] e;
    iso = c & (~c + 4'd1);
    low = (c == 0) ? 0 : $clog2(iso) + 1;
    e = ov(!r && m_cur != 0 && m_age == 0,
           m_cur,
           m_cur != 0,
           m_pend != 0,
           !r && m_cur != 0 && m_acked && !l,
           !r && m_cur != 0 && !m_acked && m_age == ACK_T && !l);
    cyc("random", r, c, a, l, e);
    if (r) begin
      m_cur = 0; m_pend = 0; m_age = -1; m_acked = 1'b0;
    end else if (m_cur == 0) begin
      if (m_pend != 0) begin
        m_cur = m_pend; m_pend = low; m_age = -1;
      end else if (low != 0) begin
        m_cur = low; m_age = -1;
      end
    end else if (m_age < 0) begin
      if (low != 0) m_cur = low;
      if (a) m_age = 0;
    end else begin
      if (low != 0) m_pend = low;
      if (m_age == 0) begin
        m_age = 1; m_acked = 1'b0;
      end else if (!m_acked) begin
        if (l) m_acked = 1'b1;
        else if (m_age == ACK_T) begin m_cur = 0; m_age = -1; end
        else m_age++;
      end else if (!l) begin
        m_cur = 0; m_acked = 1'b0; m_age = -1;
      end
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit         r;
    logic [3:0] c;
    bit         a;
    bit         l;
    logic [7:0] e;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int mode;
    bit l_hold;

    tbl[0]  = '{1'b1, 4'b0000, 1'b1, 1'b0, ov(0,0,0,0,0,0)};  // in reset
    tbl[1]  = '{1'b0, 4'b0010, 1'b1, 1'b0, ov(0,0,0,0,0,0)};  // cmd cfg 2, idle
    tbl[2]  = '{1'b0, 4'b0000, 1'b1, 1'b0, ov(0,2,1,0,0,0)};  // armed
    tbl[3]  = '{1'b0, 4'b0000, 1'b1, 1'b0, ov(1,2,1,0,0,0)};  // go at t+2
    tbl[4]  = '{1'b0, 4'b0000, 1'b1, 1'b1, ov(0,2,1,0,0,0)};  // ack
    tbl[5]  = '{1'b0, 4'b0000, 1'b1, 1'b1, ov(0,2,1,0,0,0)};
    tbl[6]  = '{1'b0, 4'b0000, 1'b1, 1'b1, ov(0,2,1,0,0,0)};
    tbl[7]  = '{1'b0, 4'b0000, 1'b1, 1'b0, ov(0,2,1,0,1,0)};  // done
    tbl[8]  = '{1'b0, 4'b1100, 1'b0, 1'b0, ov(0,0,0,0,0,0)};  // two bits
    tbl[9]  = '{1'b0, 4'b0000, 1'b0, 1'b0, ov(0,3,1,0,0,0)};  // bit 2 wins
    tbl[10] = '{1'b0, 4'b0000, 1'b1, 1'b0, ov(0,3,1,0,0,0)};
    tbl[11] = '{1'b0, 4'b0000, 1'b1, 1'b0, ov(1,3,1,0,0,0)};
    tbl[12] = '{1'b0, 4'b0000, 1'b1, 1'b1, ov(0,3,1,0,0,0)};
    tbl[13] = '{1'b0, 4'b0000, 1'b1, 1'b0, ov(0,3,1,0,1,0)};
    tbl[14] = '{1'b0, 4'b0000, 1'b1, 1'b0, ov(0,0,0,0,0,0)};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++)
      cyc($sformatf("table_%0d", i), tbl[i].r, tbl[i].c, tbl[i].a, tbl[i].l, tbl[i].e);

    // allowed held low: no go; a later command overwrites the armed request
    cyc("s3_cmd", 0, 4'b0001, 0, 0, ov(0,0,0,0,0,0));
    for (int i = 0; i < 10; i++)
      cyc("s3_hold", 0, (i == 4) ? 4'b1000 : 4'b0000, 0, 0,
          ov(0, (i <= 4) ? 1 : 4, 1, 0, 0, 0));
    cyc("s3_allow", 0, 4'b0000, 1, 0, ov(0,4,1,0,0,0));
    cyc("s3_go",    0, 4'b0000, 0, 0, ov(1,4,1,0,0,0));  // allowed drop ignored
    cyc("s3_ack",   0, 4'b0000, 0, 1, ov(0,4,1,0,0,0));
    cyc("s3_done",  0, 4'b0000, 0, 0, ov(0,4,1,0,1,0));
    cyc("s3_idle",  0, 4'b0000, 0, 0, ov(0,0,0,0,0,0));

    // pending slot: cfg 2 then cfg 3 during the load, only cfg 3 is served
    cyc("s4_cmd",   0, 4'b0001, 1, 0, ov(0,0,0,0,0,0));
    cyc("s4_arm",   0, 4'b0000, 1, 0, ov(0,1,1,0,0,0));
    cyc("s4_go",    0, 4'b0000, 1, 0, ov(1,1,1,0,0,0));
    cyc("s4_ack",   0, 4'b0000, 1, 1, ov(0,1,1,0,0,0));
    cyc("s4_pend2", 0, 4'b0010, 1, 1, ov(0,1,1,0,0,0));
    cyc("s4_pend3", 0, 4'b0100, 1, 1, ov(0,1,1,1,0,0));
    cyc("s4_done",  0, 4'b0000, 1, 0, ov(0,1,1,1,1,0));
    cyc("s4_idle",  0, 4'b0000, 1, 0, ov(0,0,0,1,0,0));
    cyc("s4_arm3",  0, 4'b0000, 1, 0, ov(0,3,1,0,0,0));
    cyc("s4_go3",   0, 4'b0000, 1, 0, ov(1,3,1,0,0,0));
    cyc("s4_ack3",  0, 4'b0000, 1, 1, ov(0,3,1,0,0,0));
    cyc("s4_done3", 0, 4'b0000, 1, 0, ov(0,3,1,0,1,0));
    cyc("s4_empty", 0, 4'b0000, 1, 0, ov(0,0,0,0,0,0));

    // watchdog: timeout 16 cycles after go; pending survives the abort
    cyc("s5_cmd",   0, 4'b0001, 1, 0, ov(0,0,0,0,0,0));
    cyc("s5_arm",   0, 4'b0000, 1, 0, ov(0,1,1,0,0,0));
    cyc("s5_go",    0, 4'b0000, 1, 0, ov(1,1,1,0,0,0));
    for (int k = 1; k <= ACK_T; k++)
      cyc($sformatf("s5_wait_%0d", k), 0, (k == 5) ? 4'b0100 : 4'b0000, 1, 0,
          ov(0, 1, 1, k > 5, 0, k == ACK_T));
    cyc("s5_idle",  0, 4'b0000, 0, 0, ov(0,0,0,1,0,0));
    cyc("s5_arm3",  0, 4'b0000, 0, 0, ov(0,3,1,0,0,0));

    // reset during a load with a pending request
    cyc("s6_allow", 0, 4'b0000, 1, 0, ov(0,3,1,0,0,0));
    cyc("s6_go",    0, 4'b0000, 1, 0, ov(1,3,1,0,0,0));
    cyc("s6_ack",   0, 4'b0000, 1, 1, ov(0,3,1,0,0,0));
    cyc("s6_pend",  0, 4'b0001, 1, 1, ov(0,3,1,0,0,0));
    cyc("s6_rst",   1, 4'b0000, 1, 0, ov(0,3,1,1,0,0));
    cyc("s6_after", 0, 4'b0000, 1, 0, ov(0,0,0,0,0,0));
    cyc("s6_quiet", 0, 4'b0000, 1, 0, ov(0,0,0,0,0,0));

    // randomized traffic against the model
    m_cur = 0; m_pend = 0; m_age = -1; m_acked = 1'b0;
    l_hold = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] c;
      bit a, l, r;
      mode = (i / 150) % 3;
      c = ($urandom_range(0, 6) == 0) ? N'($urandom_range(0, 15)) : '0;
      a = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) l_hold = ~l_hold;
      case (mode)
        0:       l = ($urandom_range(0, 1) == 1);
        1:       l = 1'b0;
        default: l = l_hold;
      endcase
      rcyc(r, c, a, l);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
